uart_data_tx: RTL and testbench
===============================

Name: uart_data_tx

Overview:
Multi-byte UART transmitter. On a start strobe it captures a DATA_WIDTH-bit word and sends it as DATA_WIDTH/8 back-to-back 8N1 frames on a single serial line. The baud rate is chosen at run time from an 8-entry table. It sits between a register or control interface and the physical TX pin. It reports a busy flag and a one-cycle completion pulse.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of 8, minimum 8. NBYTES = DATA_WIDTH/8.
- MSB_FIRST, 0: byte order on the line. 0 sends the least-significant byte first; 1 sends the most-significant byte first.
- CLK_FREQ, 50_000_000: clock frequency in Hz, used to derive bit periods.

Ports:
- Clk  in  1  system clock. Single clock domain.
- Rst  in  1  reset. One clock; reset is synchronous and active-high.
- data  in  DATA_WIDTH  word to send. Sampled only on an accepted send_en.
- send_en  in  1  start strobe, normally one cycle wide.
- Baud_Set  in  3  baud select. Sampled on an accepted send_en.
- uart_tx  out  1  serial output. Idles high.
- Tx_Done  out  1  one-cycle pulse when the whole word has been sent.
- uart_state  out  1  busy flag. High from the first start bit to the end of the last stop bit.

Behaviour:
- Reset values: uart_tx=1, Tx_Done=0, uart_state=0. All counters are zeroed and the FSM goes to IDLE.
- Baud table: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5=230400, 6=460800, 7=921600. All 8 codes are valid.
  - BIT_CYC = CLK_FREQ/baud, integer-truncated. At 50 MHz, code 4 gives 434 cycles.
- Accept rule: send_en is accepted on a rising Clk edge when uart_state=0 and Rst=0.
  - data and Baud_Set are latched into internal registers on that edge.
  - send_en while busy is ignored. The latched data is unaffected by later changes to the inputs.
- Latency: on the edge after acceptance, uart_tx=0 (start bit) and uart_state=1.
- Frame format, per byte: start bit 0, then 8 data bits LSB first, then stop bit 1. Each bit is held for exactly BIT_CYC cycles.
- Byte sequencing: the byte index runs 0..NBYTES-1.
  - MSB_FIRST=0: byte k is data[8k+7:8k].
  - MSB_FIRST=1: byte k is data[DATA_WIDTH-1-8k -: 8].
  - The next start bit follows the previous stop bit with no idle gap.
- Total busy time: NBYTES*10*BIT_CYC cycles.
- FSM states: IDLE -> START -> DATA(bit 0..7) -> STOP -> (START for the next byte | DONE) -> IDLE.
  - A bit-period counter counts 0..BIT_CYC-1. The state advances when it wraps.
- Completion: when the last stop bit's period ends, Tx_Done=1 for exactly one cycle.
  - uart_state falls to 0 on that same edge and uart_tx stays 1.
  - A send_en on the Tx_Done cycle is accepted, since uart_state is 0.
- Reset mid-operation: on the next edge uart_tx=1, uart_state=0 and Tx_Done=0. The frame is abandoned with no Tx_Done.
- Rst together with send_en: reset wins.

Decomposition:
- Package uart_pkg holds:
  - a baud lookup function (Baud_Set, CLK_FREQ) -> BIT_CYC;
  - the baud code constants;
  - the FSM state enum.
- Sub-module uart_byte_tx: single 8N1 byte transmitter with its own busy/done. The top level sequences bytes and selects byte order.

Test Plan:
- Reset: hold Rst for 10 cycles -> uart_tx=1, uart_state=0, Tx_Done=0 throughout; no toggling after release.
- LSB-first word, MSB_FIRST=0, Baud_Set=4, 50 MHz: data=32'h01234567, 1-cycle send_en.
  - Bytes appear in order 0x67, 0x45, 0x23, 0x01.
  - First frame bits are 0,1,1,1,0,0,1,1,0,1, each 434 cycles.
  - Tx_Done pulses once, exactly 17360 cycles after uart_tx first falls.
- Back-to-back words: after each Tx_Done, send 32'h12345678 then 32'h23456789 -> each decodes correctly, one Tx_Done per word.
- MSB-first build, MSB_FIRST=1: data=32'h01234567 -> byte order 0x01, 0x23, 0x45, 0x67.
- Busy and baud checks:
  - send_en pulses while busy, with data changed mid-frame -> ignored; the original word is transmitted intact.
  - Baud_Set=0 -> bit period 5208 cycles.
- Reset mid-frame: assert Rst during byte 2 -> uart_tx=1 and uart_state=0 next cycle, no Tx_Done. A subsequent send then works normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: baud table, bit-period lookup and transmitter state encoding
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;
    localparam logic [2:0] BAUD_230400 = 3'd5;
    localparam logic [2:0] BAUD_460800 = 3'd6;
    localparam logic [2:0] BAUD_921600 = 3'd7;
    localparam int unsigned BAUD_RATE [8] = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    function automatic int unsigned baud_cycles(input logic [2:0] sel, input int unsigned clk_freq);
        return clk_freq / BAUD_RATE[sel];
    endfunction
endpackage

// File: rtl/uart_data_tx_byte_tx.sv
// uart_byte_tx: single 8N1 byte transmitter with run-time bit period
module uart_byte_tx import uart_pkg::*; #(
    parameter int CNT_W = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       byte_in,
    input  logic [CNT_W-1:0] cyc_in,
    output logic             tx,
    output logic             busy,
    output logic             done
);
    state_t st, st_nx;
    logic [CNT_W-1:0] cnt, cyc;
    logic [2:0] bitn, bit_nx;
    logic [7:0] sh;
    logic wrap, load, tx_nx;
    always_comb begin
        wrap = cnt == cyc - 1'b1;
        done = st == STOP && wrap;
        busy = st != IDLE;
        load = start && (st == IDLE || done);
        bit_nx = (st == DATA && wrap) ? bitn + 1'b1 : bitn;
        st_nx = st == IDLE ? (start ? START : IDLE)
              : !wrap ? st
              : st == START ? DATA
              : st == DATA ? (bitn == 3'd7 ? STOP : DATA)
              : start ? START : IDLE;
        tx_nx = st_nx == START ? 1'b0 : st_nx == DATA ? sh[bit_nx] : 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            cnt  <= '0;
            cyc  <= '0;
            bitn <= '0;
            sh   <= '0;
            tx   <= 1'b1;
        end else begin
            st   <= st_nx;
            cnt  <= (st == IDLE || wrap) ? '0 : cnt + 1'b1;
            cyc  <= load ? cyc_in : cyc;
            bitn <= bit_nx;
            sh   <= load ? byte_in : sh;
            tx   <= tx_nx;
        end
    end
endmodule

// File: rtl/uart_data_tx.sv
// uart_data_tx: multi-byte 8N1 word transmitter with run-time baud select
module uart_data_tx import uart_pkg::*; #(
    parameter int          DATA_WIDTH = 32,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned CLK_FREQ   = 50_000_000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  send_en,
    input  logic [2:0]            Baud_Set,
    output logic                  uart_tx,
    output logic                  Tx_Done,
    output logic                  uart_state
);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam int CNT_W = $clog2(CLK_FREQ / BAUD_RATE[BAUD_9600] + 1);
    state_t st, st_nx;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0] baud_q;
    logic [IW-1:0] idx;
    logic accept, last, byte_start, byte_done, byte_busy;
    logic [7:0] byte_sel;
    logic [CNT_W-1:0] cyc_sel;
    function automatic logic [7:0] pick(input logic [DATA_WIDTH-1:0] w, input int k);
        return MSB_FIRST ? w[DATA_WIDTH-1-8*k -: 8] : w[8*k +: 8];
    endfunction
    always_comb begin
        accept = send_en && !byte_busy;
        last = idx == IW'(NBYTES - 1);
        byte_start = accept || (byte_done && !last);
        byte_sel = accept ? pick(data, 0) : pick(data_q, last ? 0 : int'(idx) + 1);
        cyc_sel = CNT_W'(baud_cycles(accept ? Baud_Set : baud_q, CLK_FREQ));
        st_nx = accept ? DATA
              : (st == DATA && byte_done && last) ? DONE
              : st == DONE ? IDLE : st;
        uart_state = st == DATA;
        Tx_Done = st == DONE;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            st     <= IDLE;
            data_q <= '0;
            baud_q <= '0;
            idx    <= '0;
        end else begin
            st <= st_nx;
            if (accept) begin
                data_q <= data;
                baud_q <= Baud_Set;
                idx    <= '0;
            end else if (byte_done && !last) begin
                idx <= idx + 1'b1;
            end
        end
    end
    uart_byte_tx #(.CNT_W(CNT_W)) u_byte (
        .clk(Clk),
        .rst(Rst),
        .start(byte_start),
        .byte_in(byte_sel),
        .cyc_in(cyc_sel),
        .tx(uart_tx),
        .busy(byte_busy),
        .done(byte_done)
    );
endmodule

// File: tb/tb_uart_data_tx.sv
// tb_uart_data_tx: LSB-first and MSB-first instances driven in parallel, decoded by a frame monitor
module tb_uart_data_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic send_en = 1'b0;
    logic [31:0] data = '0;
    logic [2:0] baud = '0;
    wire [1:0] tx, done, busy;
    always #5 clk = ~clk;
    uart_data_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b0), .CLK_FREQ(50_000_000)) u_lsb (
        .Clk(clk), .Rst(rst), .data(data), .send_en(send_en), .Baud_Set(baud),
        .uart_tx(tx[0]), .Tx_Done(done[0]), .uart_state(busy[0]));
    uart_data_tx #(.DATA_WIDTH(32), .MSB_FIRST(1'b1), .CLK_FREQ(50_000_000)) u_msb (
        .Clk(clk), .Rst(rst), .data(data), .send_en(send_en), .Baud_Set(baud),
        .uart_tx(tx[1]), .Tx_Done(done[1]), .uart_state(busy[1]));
    int n_cmp = 0;
    int n_bad = 0;
    int mon_b = 434;
    logic mon_clr = 1'b0;
    logic [7:0] sb [2][$];
    int busy_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int bb [2] = '{0, 0};
    typedef struct {
        logic [31:0] d;
        logic [2:0]  b;
        int          cyc;
        int          busy_cyc;
        bit          poke;
    } vec_t;
    vec_t vt [4];
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (done[g] === 1'b1) done_cnt[g]++;
            if (busy[g] === 1'b1) busy_cnt[g]++;
        end
    end
    for (genvar g = 0; g < 2; g++) begin : mon
        int cnt = 0;
        int j;
        logic act = 1'b0;
        logic [7:0] sh = '0;
        always @(negedge clk) begin
            if (mon_clr) begin
                act = 1'b0;
            end else begin
                if (!act && tx[g] === 1'b0) begin
                    act = 1'b1;
                    cnt = 0;
                end
                if (act) begin
                    cnt++;
                    if (cnt % mon_b == mon_b / 2) begin
                        j = cnt / mon_b;
                        if (j == 0) check($sformatf("ch%0d start bit", g), tx[g], 1'b0);
                        else if (j < 9) sh[j-1] = tx[g];
                        else begin
                            check($sformatf("ch%0d stop bit", g), tx[g], 1'b1);
                            if (sb[g].size() == 0) begin
                                n_cmp++;
                                n_bad++;
                                $display("FAIL ch%0d unexpected byte: got 0x%0h, required none", g, sh);
                            end else check($sformatf("ch%0d byte", g), sh, sb[g].pop_front());
                        end
                    end
                    if (cnt == 10 * mon_b) act = 1'b0;
                end
            end
        end
    end
    task automatic send(input logic [31:0] d, input logic [2:0] b);
        for (int k = 0; k < 4; k++) begin
            sb[0].push_back(d[8*k +: 8]);
            sb[1].push_back(d[31-8*k -: 8]);
        end
        bb[0] = busy_cnt[0];
        bb[1] = busy_cnt[1];
        data = d;
        baud = b;
        send_en = 1'b1;
        tick();
        send_en = 1'b0;
        check("start latency {tx,busy,done}", {tx, busy, done}, 6'b00_11_00);
    endtask
    task automatic wait_done(input int bound);
        int n = 0;
        while (done !== 2'b11 && n < bound) begin
            tick();
            n++;
        end
        if (done !== 2'b11) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done timeout: done=%b, required 11", done);
        end
    endtask
    task automatic check_word(input int busy_cyc);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("ch%0d busy cycles", g), busy_cnt[g] - bb[g], busy_cyc);
            check($sformatf("ch%0d bytes left", g), sb[g].size(), 0);
        end
        check("idle at done {tx,busy}", {tx, busy}, 4'b11_00);
    endtask
    task automatic abort();
        rst = 1'b1;
        mon_clr = 1'b1;
        tick();
        rst = 1'b0;
        mon_clr = 1'b0;
        sb[0].delete();
        sb[1].delete();
        check("idle after reset {tx,busy,done}", {tx, busy, done}, 6'b11_00_00);
    endtask
    initial begin
        int k;
        int d0 [2];
        vt[0] = '{32'h01234567, 3'd4, 434, 17360, 1'b0};
        vt[1] = '{32'h12345678, 3'd4, 434, 17360, 1'b1};
        vt[2] = '{32'h23456789, 3'd4, 434, 17360, 1'b0};
        vt[3] = '{32'h5AC3E781, 3'd7, 54, 2160, 1'b1};
        repeat (9) begin
            tick();
            check("in reset {tx,busy,done}", {tx, busy, done}, 6'b11_00_00);
        end
        send_en = 1'b1;
        data = 32'hDEADBEEF;
        tick();
        send_en = 1'b0;
        rst = 1'b0;
        check("reset beats send_en", {tx, busy, done}, 6'b11_00_00);
        repeat (20) begin
            tick();
            check("idle after release", {tx, busy, done}, 6'b11_00_00);
        end
        for (int i = 0; i < 4; i++) begin
            mon_b = vt[i].cyc;
            send(vt[i].d, vt[i].b);
            if (vt[i].poke) begin
                repeat (1000) tick();
                data = 32'hFFFF_FFFF;
                baud = 3'd0;
                send_en = 1'b1;
                tick();
                send_en = 1'b0;
                data = '0;
                repeat (3) tick();
                send_en = 1'b1;
                tick();
                send_en = 1'b0;
            end
            wait_done(vt[i].busy_cyc + vt[i].busy_cyc / 4);
            check_word(vt[i].busy_cyc);
        end
        tick();
        check("one-cycle done", {tx, busy, done}, 6'b11_00_00);
        mon_b = 54;
        send(32'hA5C3E781, 3'd7);
        repeat (1180) tick();
        d0[0] = done_cnt[0];
        d0[1] = done_cnt[1];
        abort();
        repeat (200) tick();
        check("no done after abort", {done_cnt[0] - d0[0], done_cnt[1] - d0[1]}, 64'd0);
        check("idle after abort", {tx, busy, done}, 6'b11_00_00);
        send(32'h3C96F00F, 3'd7);
        wait_done(3000);
        check_word(2160);
        tick();
        mon_b = 5208;
        send(32'hFF0000FF, 3'd0);
        k = 0;
        while (tx === 2'b00 && k < 6000) begin
            tick();
            k++;
        end
        check("baud 0 start bit cycles", k, 5208);
        check("baud 0 first data bit", tx, 2'b11);
        abort();
        check("ch0 total done pulses", done_cnt[0], 5);
        check("ch1 total done pulses", done_cnt[1], 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
